issue_queue_mp: RTL and testbench
=================================

Name: issue_queue_mp

Overview:
- Parametrised out-of-order issue queue (reservation station). Sits between rename/dispatch and the functional units.
- Accepts one renamed instruction per cycle and captures operands from ARF/ROB, or later from the CDB (wakeup).
- Each cycle, selects at most one ready entry per issue port; port p serves FU class p.
- Adds over the previous generation: entry allocation/free tracking, CDB wakeup, per-port select, full backpressure, flush.

Parameters:
- IQ_SIZE, 16, number of entries (power of 2, 4..64).
- ISSUE_PORTS, 3, issue ports = FU classes = CDB ports (1..4).
- REG_SIZE, 32, operand data width.
- NUM_TAGS_LOG2, 6, physical tag width.
- ROB_SIZE_LOG2, 6, ROB index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  squash all entries.
- stall_in  in  1  suppress issue this cycle.
- in_valid  in  1  dispatch request.
- in_ready  out  1  entry available (IQ not full).
- op  in  5  operation code.
- fu_class  in  2  target port (< ISSUE_PORTS).
- rob_idx  in  ROB_SIZE_LOG2  ROB index.
- tag_rd / tag_rs1 / tag_rs2  in  NUM_TAGS_LOG2 each  destination / source tags.
- src_rdy  in  2  [0] rs1, [1] rs2 data valid at dispatch.
- data_rs1 / data_rs2  in  REG_SIZE each  operand data (ARF or ROB, pre-muxed).
- imm_sel  in  1  src2 is the immediate.
- imm  in  32  immediate.
- cdb_valid  in  ISSUE_PORTS  per-port result valid.
- cdb_tags  in  ISSUE_PORTS x NUM_TAGS_LOG2  result tags.
- cdb_data  in  ISSUE_PORTS x REG_SIZE  result data.
- fu_valid  out  ISSUE_PORTS  issue valid.
- fu_op  out  ISSUE_PORTS x 5  op.
- fu_rs1 / fu_rs2  out  ISSUE_PORTS x REG_SIZE  operands.
- fu_tags  out  ISSUE_PORTS x NUM_TAGS_LOG2  rd tag.
- fu_rob  out  ISSUE_PORTS x ROB_SIZE_LOG2  ROB index.
- occupancy  out  $clog2(IQ_SIZE)+1  valid entry count.

Behaviour:
- Reset (rst low, async): all entry valid bits 0, fu_valid 0, all fu_* 0, occupancy 0, in_ready 1.
- Entry state: valid, fu_class, op, rob, rd tag, two src tags, two src ready bits, two data fields.
- Dispatch:
  - Accepted on the clk edge when in_valid && in_ready.
  - Written to the lowest-index free entry; entry is valid after that edge.
  - in_ready = (occupancy < IQ_SIZE), registered view. Entries freed by issue in the same cycle are not reusable until the next cycle.
- imm_sel=1: src2 ready=1, data2=imm, tag_rs2 ignored.
- Wakeup:
  - Every edge, each valid entry with a not-ready source compares its tag against all cdb ports with cdb_valid=1.
  - On match, capture cdb_data and set ready. Lowest-numbered port wins on duplicate tags.
  - The dispatching instruction is also checked (same-cycle bypass): a CDB match overrides src_rdy=0 data.
- Select (combinational from registered state):
  - An entry is eligible when valid && both srcs ready && fu_class==p.
  - Port p takes the lowest-index eligible entry.
- Issue: on the edge, fu_* registered from the selected entry, fu_valid[p]=1, entry valid cleared. Latency:
  - Dispatched ready at edge N: issued at edge N+1.
  - Woken at edge K: issued at edge K+1.
- stall_in=1: no selection; fu_valid all 0 next edge; entries retained; wakeup and dispatch continue.
- flush=1: all valid bits cleared and fu_valid 0 at that edge. Flush dominates the dispatch and issue in that cycle. occupancy becomes 0.
- occupancy next = occupancy + dispatched − issued; flush sets it to 0.
- Full: in_valid ignored when in_ready=0, with no state change.
- No port may issue the same entry twice. An entry not matching any port class never issues (illegal fu_class is a rename bug; assert in sim).

Optional Feature:
- IQ_AGE_SELECT_EN defined:
  - Each port selects the oldest eligible entry by ROB age, measured as (rob − rob_head) mod 2^ROB_SIZE_LOG2.
  - Adds input rob_head [ROB_SIZE_LOG2-1:0].
  - Ties impossible (unique rob).
- Undefined: lowest-index selection, no rob_head port.

Decomposition:
- Shared package iq_pkg:
  - iq_entry_t struct.
  - FU class encodings: ALU=0, MEM=1, BR=2, MUL=3.
  - Width constants REG_SIZE, NUM_TAGS_LOG2, ROB_SIZE_LOG2.
- Sub-module iq_select: N-bit request vector (plus optional ages) -> one-hot grant + valid. Instantiated once per port; also reused for free-entry allocation.

Test Plan:
- Reset, then dispatch op=5, fu_class=0, src_rdy=11, data 7/9, rob=3 -> next cycle fu_valid[0]=1, fu_rs1=7, fu_rs2=9, fu_rob=3; occupancy 1→0.
- Dispatch with src_rdy[0]=0, tag_rs1=12; three cycles later cdb_valid[1]=1, cdb_tags[1]=12, cdb_data[1]=0xAA -> issue one cycle after the CDB, fu_rs1=0xAA.
- Fill 16 entries with unready sources -> in_ready=0 at occupancy 16; a 17th in_valid is dropped; one wakeup+issue -> in_ready=1 next cycle.
- Two ready class-0 entries at indices 2 and 5 plus one class-2 at index 4 -> same cycle port0 issues entry 2, port2 issues entry 4; port0 issues entry 5 next.
- flush asserted together with in_valid and a ready entry -> no issue, occupancy 0, dispatch lost; async rst low mid-stream -> outputs 0 immediately.
- IQ_AGE_SELECT_EN: rob_head=60, entries rob=2 (idx0) and rob=62 (idx1), both ready class 0 -> entry idx1 issues first.

Source files
------------

// File: rtl/iq_pkg.sv
// iq_pkg: shared widths, FU class codes and entry layout
// for issue_queue_mp. Optional build macro: IQ_AGE_SELECT_EN.
package iq_pkg;

  localparam int REG_SIZE      = 32;
  localparam int NUM_TAGS_LOG2 = 6;
  localparam int ROB_SIZE_LOG2 = 6;
  localparam int OP_W          = 5;
  localparam int CLS_W         = 2;

  typedef enum logic [CLS_W-1:0] {
    FU_ALU = 2'd0,
    FU_MEM = 2'd1,
    FU_BR  = 2'd2,
    FU_MUL = 2'd3
  } fu_class_e;

  typedef struct packed {
    logic                     valid;
    fu_class_e                fu_class;
    logic [OP_W-1:0]          op;
    logic [ROB_SIZE_LOG2-1:0] rob;
    logic [NUM_TAGS_LOG2-1:0] tag_rd;
    logic [NUM_TAGS_LOG2-1:0] tag_rs1;
    logic [NUM_TAGS_LOG2-1:0] tag_rs2;
    logic                     rdy1;
    logic                     rdy2;
    logic [REG_SIZE-1:0]      data1;
    logic [REG_SIZE-1:0]      data2;
  } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// iq_select: request vector -> one-hot grant. Lowest index wins,
// or smallest age when IQ_AGE_SELECT_EN is defined.
module iq_select #(
  parameter int N = 16
`ifdef IQ_AGE_SELECT_EN
  , parameter int AW = 6
`endif
) (
  input  logic [N-1:0]         req,
`ifdef IQ_AGE_SELECT_EN
  input  logic [N-1:0][AW-1:0] age,
`endif
  output logic [N-1:0]         gnt,
  output logic                 vld
);

`ifdef IQ_AGE_SELECT_EN
  logic [AW-1:0] best;
`endif

  // pick one requester; strict compare keeps lowest index on ties
  always_comb begin
    gnt = '0;
    vld = 1'b0;
`ifdef IQ_AGE_SELECT_EN
    best = '0;
`endif
    for (int i = 0; i < N; i++) begin
`ifdef IQ_AGE_SELECT_EN
      if (req[i] && (!vld || age[i] < best)) begin
        best = age[i];
`else
      if (req[i] && !vld) begin
`endif
        gnt    = '0;
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_mp.sv
// issue_queue_mp: multi-port OoO issue queue with CDB wakeup.
// Optional build macro: IQ_AGE_SELECT_EN (oldest-first select).
module issue_queue_mp
  import iq_pkg::*;
#(
  parameter int IQ_SIZE     = 16,
  parameter int ISSUE_PORTS = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      stall_in,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [OP_W-1:0]                           op,
  input  logic [CLS_W-1:0]                          fu_class,
  input  logic [ROB_SIZE_LOG2-1:0]                  rob_idx,
  input  logic [NUM_TAGS_LOG2-1:0]                  tag_rd,
  input  logic [NUM_TAGS_LOG2-1:0]                  tag_rs1,
  input  logic [NUM_TAGS_LOG2-1:0]                  tag_rs2,
  input  logic [1:0]                                src_rdy,
  input  logic [REG_SIZE-1:0]                       data_rs1,
  input  logic [REG_SIZE-1:0]                       data_rs2,
  input  logic                                      imm_sel,
  input  logic [31:0]                               imm,
`ifdef IQ_AGE_SELECT_EN
  input  logic [ROB_SIZE_LOG2-1:0]                  rob_head,
`endif
  input  logic [ISSUE_PORTS-1:0]                    cdb_valid,
  input  logic [ISSUE_PORTS-1:0][NUM_TAGS_LOG2-1:0] cdb_tags,
  input  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]      cdb_data,
  output logic [ISSUE_PORTS-1:0]                    fu_valid,
  output logic [ISSUE_PORTS-1:0][OP_W-1:0]          fu_op,
  output logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]      fu_rs1,
  output logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]      fu_rs2,
  output logic [ISSUE_PORTS-1:0][NUM_TAGS_LOG2-1:0] fu_tags,
  output logic [ISSUE_PORTS-1:0][ROB_SIZE_LOG2-1:0] fu_rob,
  output logic [$clog2(IQ_SIZE):0]                  occupancy
);

  localparam int OCC_W = $clog2(IQ_SIZE) + 1;

  iq_entry_t ent     [IQ_SIZE];
  iq_entry_t ent_nxt [IQ_SIZE];
  iq_entry_t iss_ent [ISSUE_PORTS];
  iq_entry_t new_ent;

  logic [IQ_SIZE-1:0]                  free_vec;
  logic [IQ_SIZE-1:0]                  alloc_gnt;
  logic [IQ_SIZE-1:0]                  issued;
  logic                                alloc_vld;
  logic [ISSUE_PORTS-1:0][IQ_SIZE-1:0] req;
  logic [ISSUE_PORTS-1:0][IQ_SIZE-1:0] gnt;
  logic [ISSUE_PORTS-1:0]              sel_vld;
  logic                                disp;
  logic [OCC_W-1:0]                    n_iss;
  logic [OCC_W-1:0]                    occ_nxt;

  assign in_ready = (occupancy < OCC_W'(IQ_SIZE));
  assign disp     = in_valid && in_ready && alloc_vld && !flush;
  assign occ_nxt  = flush ? '0
                  : occupancy + OCC_W'(disp) - n_iss;

  // build the incoming entry, including same-cycle CDB bypass
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.fu_class = fu_class_e'(fu_class);
    new_ent.op       = op;
    new_ent.rob      = rob_idx;
    new_ent.tag_rd   = tag_rd;
    new_ent.tag_rs1  = tag_rs1;
    new_ent.tag_rs2  = tag_rs2;
    new_ent.rdy1     = src_rdy[0];
    new_ent.data1    = data_rs1;
    new_ent.rdy2     = src_rdy[1] | imm_sel;
    new_ent.data2    = imm_sel ? imm : data_rs2;
    for (int p = ISSUE_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p]) begin
        if (!src_rdy[0] && cdb_tags[p] == tag_rs1) begin
          new_ent.rdy1  = 1'b1;
          new_ent.data1 = cdb_data[p];
        end
        if (!src_rdy[1] && !imm_sel &&
            cdb_tags[p] == tag_rs2) begin
          new_ent.rdy2  = 1'b1;
          new_ent.data2 = cdb_data[p];
        end
      end
    end
  end

  // per-port eligibility and free-slot vector from registered state
  always_comb begin
    req      = '0;
    free_vec = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      free_vec[i] = !ent[i].valid;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        req[p][i] = !stall_in && ent[i].valid &&
                    ent[i].rdy1 && ent[i].rdy2 &&
                    int'(ent[i].fu_class) == p;
      end
    end
  end

`ifdef IQ_AGE_SELECT_EN
  logic [IQ_SIZE-1:0][ROB_SIZE_LOG2-1:0] age;

  // distance from the ROB head; smaller is older
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      age[i] = ent[i].rob - rob_head;
    end
  end
`endif

  for (genvar p = 0; p < ISSUE_PORTS; p++) begin : g_port
    iq_select #(
      .N  (IQ_SIZE)
`ifdef IQ_AGE_SELECT_EN
      , .AW (ROB_SIZE_LOG2)
`endif
    ) u_sel (
      .req (req[p]),
`ifdef IQ_AGE_SELECT_EN
      .age (age),
`endif
      .gnt (gnt[p]),
      .vld (sel_vld[p])
    );
  end

  iq_select #(
    .N  (IQ_SIZE)
`ifdef IQ_AGE_SELECT_EN
    , .AW (ROB_SIZE_LOG2)
`endif
  ) u_alloc (
    .req (free_vec),
`ifdef IQ_AGE_SELECT_EN
    .age ('0),
`endif
    .gnt (alloc_gnt),
    .vld (alloc_vld)
  );

  // mux the granted entries out and count issues
  always_comb begin
    issued = '0;
    n_iss  = '0;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      iss_ent[p] = '0;
      n_iss      = n_iss + OCC_W'(sel_vld[p]);
      for (int i = 0; i < IQ_SIZE; i++) begin
        if (gnt[p][i]) begin
          iss_ent[p] = ent[i];
          issued[i]  = 1'b1;
        end
      end
    end
  end

  // next entry state: wakeup, issue clear, allocate, flush
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].valid) begin
        for (int p = ISSUE_PORTS - 1; p >= 0; p--) begin
          if (cdb_valid[p]) begin
            if (!ent[i].rdy1 &&
                cdb_tags[p] == ent[i].tag_rs1) begin
              ent_nxt[i].rdy1  = 1'b1;
              ent_nxt[i].data1 = cdb_data[p];
            end
            if (!ent[i].rdy2 &&
                cdb_tags[p] == ent[i].tag_rs2) begin
              ent_nxt[i].rdy2  = 1'b1;
              ent_nxt[i].data2 = cdb_data[p];
            end
          end
        end
      end
      if (issued[i]) ent_nxt[i].valid = 1'b0;
      if (disp && alloc_gnt[i]) ent_nxt[i] = new_ent;
      if (flush) ent_nxt[i].valid = 1'b0;
    end
  end

  // entry array, occupancy and registered issue outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IQ_SIZE; i++) ent[i] <= '0;
      occupancy <= '0;
      fu_valid  <= '0;
      fu_op     <= '0;
      fu_rs1    <= '0;
      fu_rs2    <= '0;
      fu_tags   <= '0;
      fu_rob    <= '0;
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) ent[i] <= ent_nxt[i];
      occupancy <= occ_nxt;
      fu_valid  <= flush ? '0 : sel_vld;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (sel_vld[p] && !flush) begin
          fu_op[p]   <= iss_ent[p].op;
          fu_rs1[p]  <= iss_ent[p].data1;
          fu_rs2[p]  <= iss_ent[p].data2;
          fu_tags[p] <= iss_ent[p].tag_rd;
          fu_rob[p]  <= iss_ent[p].rob;
        end
      end
    end
  end

  // an entry for a nonexistent port would sit forever
  a_fu_class: assert property (
    @(posedge clk) disable iff (!rst)
    (in_valid && in_ready) |-> (int'(fu_class) < ISSUE_PORTS)
  );

endmodule

// File: tb/tb_issue_queue_mp.sv
// tb_issue_queue_mp: directed stimulus, per-port scoreboard
// for issue_queue_mp (default or IQ_AGE_SELECT_EN build).
module tb_issue_queue_mp;

  localparam int P = 3;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  tag;
    logic [5:0]  rob;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic stall_in = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] op = '0;
  logic [1:0] fu_class = '0;
  logic [5:0] rob_idx = '0;
  logic [5:0] tag_rd = '0;
  logic [5:0] tag_rs1 = '0;
  logic [5:0] tag_rs2 = '0;
  logic [1:0] src_rdy = '0;
  logic [31:0] data_rs1 = '0;
  logic [31:0] data_rs2 = '0;
  logic imm_sel = 1'b0;
  logic [31:0] imm = '0;
`ifdef IQ_AGE_SELECT_EN
  logic [5:0] rob_head = '0;
`endif
  logic [P-1:0] cdb_valid = '0;
  logic [P-1:0][5:0] cdb_tags = '0;
  logic [P-1:0][31:0] cdb_data = '0;
  logic [P-1:0] fu_valid;
  logic [P-1:0][4:0] fu_op;
  logic [P-1:0][31:0] fu_rs1;
  logic [P-1:0][31:0] fu_rs2;
  logic [P-1:0][5:0] fu_tags;
  logic [P-1:0][5:0] fu_rob;
  logic [4:0] occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  issue_queue_mp #(.IQ_SIZE(16), .ISSUE_PORTS(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_in  (stall_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .fu_class  (fu_class),
    .rob_idx   (rob_idx),
    .tag_rd    (tag_rd),
    .tag_rs1   (tag_rs1),
    .tag_rs2   (tag_rs2),
    .src_rdy   (src_rdy),
    .data_rs1  (data_rs1),
    .data_rs2  (data_rs2),
    .imm_sel   (imm_sel),
    .imm       (imm),
`ifdef IQ_AGE_SELECT_EN
    .rob_head  (rob_head),
`endif
    .cdb_valid (cdb_valid),
    .cdb_tags  (cdb_tags),
    .cdb_data  (cdb_data),
    .fu_valid  (fu_valid),
    .fu_op     (fu_op),
    .fu_rs1    (fu_rs1),
    .fu_rs2    (fu_rs2),
    .fu_tags   (fu_tags),
    .fu_rob    (fu_rob),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push(input int p, input exp_t e);
    case (p)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] o, input logic [1:0] c,
                     input logic [5:0] rb, input logic [5:0] rd,
                     input logic [5:0] t1, input logic [5:0] t2,
                     input logic [1:0] rdy,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic is, input logic [31:0] im);
    in_valid = 1'b1;
    op       = o;
    fu_class = c;
    rob_idx  = rb;
    tag_rd   = rd;
    tag_rs1  = t1;
    tag_rs2  = t2;
    src_rdy  = rdy;
    data_rs1 = d1;
    data_rs2 = d2;
    imm_sel  = is;
    imm      = im;
  endtask

  // monitor: every issued packet must match the head of its port queue
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < P; p++) begin
        if (fu_valid[p]) begin
          exp_t act;
          exp_t want;
          int sz;
          act = exp_t'{fu_op[p], fu_rs1[p], fu_rs2[p],
                       fu_tags[p], fu_rob[p]};
          sz = (p == 0) ? q0.size() :
               (p == 1) ? q1.size() : q2.size();
          n_cmp++;
          if (sz == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected_p%0d: got %h want none",
                     p, act);
          end else begin
            case (p)
              0:       want = q0.pop_front();
              1:       want = q1.pop_front();
              default: want = q2.pop_front();
            endcase
            if (act !== want) begin
              n_bad++;
              $display("FAIL sb_p%0d: got %h want %h", p, act, want);
            end
          end
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    #10 rst = 1'b1;
    tick();

    // ready dispatch issues one edge later
    drv(5, 0, 3, 1, 0, 0, 2'b11, 7, 9, 0, 0);
    push(0, exp_t'{5'd5, 32'd7, 32'd9, 6'd1, 6'd3});
    tick(); in_valid = 1'b0;
    chk("t1_occ_disp", occupancy, 1);
    chk("t1_no_early", fu_valid, 0);
    tick();
    chk("t1_issue", fu_valid, 3'b001);
    chk("t1_occ_iss", occupancy, 0);

    // CDB wakeup three cycles after dispatch
    drv(2, 1, 4, 2, 12, 0, 2'b10, 32'hDEAD, 32'h55, 0, 0);
    tick(); in_valid = 1'b0;
    tick(); chk("t2_wait1", fu_valid, 0);
    tick(); chk("t2_wait2", fu_valid, 0);
    cdb_valid = 3'b010; cdb_tags[1] = 12; cdb_data[1] = 32'hAA;
    push(1, exp_t'{5'd2, 32'hAA, 32'h55, 6'd2, 6'd4});
    tick(); cdb_valid = '0;
    chk("t2_woken", fu_valid, 0);
    tick();
    chk("t2_issue", fu_valid, 3'b010);

    // same-cycle bypass, duplicate tag: port 0 wins; imm as src2
    drv(7, 2, 5, 3, 20, 9, 2'b00, 32'hBAD, 32'hBAD, 1, 32'h100);
    cdb_valid = 3'b011;
    cdb_tags[0] = 20; cdb_data[0] = 32'h33;
    cdb_tags[1] = 20; cdb_data[1] = 32'h44;
    push(2, exp_t'{5'd7, 32'h33, 32'h100, 6'd3, 6'd5});
    tick(); in_valid = 1'b0; cdb_valid = '0;
    tick();
    chk("byp_issue", fu_valid, 3'b100);

    // stall holds a ready entry
    stall_in = 1'b1;
    drv(3, 1, 6, 4, 0, 0, 2'b11, 1, 2, 0, 0);
    push(1, exp_t'{5'd3, 32'd1, 32'd2, 6'd4, 6'd6});
    tick(); in_valid = 1'b0;
    tick();
    chk("stall_hold", fu_valid, 0);
    chk("stall_occ", occupancy, 1);
    stall_in = 1'b0;
    tick();
    chk("stall_release", fu_valid, 3'b010);
    chk("stall_occ_after", occupancy, 0);

    // fill to full, drop the 17th, free one via wakeup
    for (int i = 0; i < 16; i++) begin
      drv(1, 0, 6'(i), 6'(i), 6'(40 + i), 0, 2'b10, 0, 32'(i), 0, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("full_occ", occupancy, 16);
    chk("full_in_ready", in_ready, 0);
    drv(9, 0, 50, 50, 0, 0, 2'b11, 1, 1, 0, 0);
    tick(); in_valid = 1'b0;
    chk("full_drop_occ", occupancy, 16);
    cdb_valid = 3'b100; cdb_tags[2] = 45; cdb_data[2] = 32'h77;
    push(0, exp_t'{5'd1, 32'h77, 32'd5, 6'd5, 6'd5});
    tick(); cdb_valid = '0;
    chk("wake_still_full", in_ready, 0);
    tick();
    chk("full_issue", fu_valid, 3'b001);
    chk("full_occ_15", occupancy, 15);
    chk("full_ready_again", in_ready, 1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_clear_occ", occupancy, 0);

    // flush beats a pending issue and a dispatch
    drv(4, 2, 7, 8, 0, 0, 2'b11, 5, 6, 0, 0);
    tick();
    drv(6, 0, 8, 9, 0, 0, 2'b11, 1, 1, 0, 0);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_issue", fu_valid, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("flush_disp_lost", fu_valid, 0);
    chk("flush_occ2", occupancy, 0);

    // per-port lowest-index select
    for (int i = 0; i < 6; i++) begin
      logic [1:0] c;
      logic [5:0] t;
      c = (i == 3 || i == 4) ? 2'd2 : 2'd0;
      t = (i == 2 || i == 4 || i == 5) ? 6'd30 : 6'd31;
      drv(5'(10 + i), c, 6'(20 + i), 6'(i), t, 0, 2'b10,
          0, 32'(256 + i), 0, 0);
      tick();
    end
    in_valid = 1'b0;
    cdb_valid = 3'b001; cdb_tags[0] = 30; cdb_data[0] = 32'h30;
    push(0, exp_t'{5'd12, 32'h30, 32'h102, 6'd2, 6'd22});
    push(0, exp_t'{5'd15, 32'h30, 32'h105, 6'd5, 6'd25});
    push(2, exp_t'{5'd14, 32'h30, 32'h104, 6'd4, 6'd24});
    tick(); cdb_valid = '0;
    tick();
    chk("prio_w1", fu_valid, 3'b101);
    chk("prio_occ1", occupancy, 4);
    tick();
    chk("prio_w2", fu_valid, 3'b001);
    chk("prio_occ2", occupancy, 3);

    // async reset mid-stream clears outputs immediately
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_fu_valid", fu_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_fu_rob", fu_rob[0], 0);
    #1 rst = 1'b1;
    tick();

    // age select: rob_head 60, rob 62 is older than rob 2
`ifdef IQ_AGE_SELECT_EN
    rob_head = 6'd60;
`endif
    drv(20, 0, 2, 10, 33, 0, 2'b10, 0, 32'hA0, 0, 0);
    tick();
    drv(21, 0, 62, 11, 33, 0, 2'b10, 0, 32'hA1, 0, 0);
    tick(); in_valid = 1'b0;
    cdb_valid = 3'b001; cdb_tags[0] = 33; cdb_data[0] = 32'h5A;
`ifdef IQ_AGE_SELECT_EN
    push(0, exp_t'{5'd21, 32'h5A, 32'hA1, 6'd11, 6'd62});
    push(0, exp_t'{5'd20, 32'h5A, 32'hA0, 6'd10, 6'd2});
`else
    push(0, exp_t'{5'd20, 32'h5A, 32'hA0, 6'd10, 6'd2});
    push(0, exp_t'{5'd21, 32'h5A, 32'hA1, 6'd11, 6'd62});
`endif
    tick(); cdb_valid = '0;
    tick();
    chk("age_w1", fu_valid, 3'b001);
    tick();
    chk("age_w2", fu_valid, 3'b001);
    tick();
    tick();
    chk("sb_drain", q0.size() + q1.size() + q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
